// File: rtl/bist_pattern_gen_if.sv
// Pattern stream handshake between the BIST pattern generator and the
// circuit-under-test side of the datapath.
interface bist_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             pat_valid;
  logic             pat_ready;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] pat_index;

  modport master (
    output pat_valid,
    output pattern,
    output pat_index,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pattern,
    input  pat_index,
    output pat_ready
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// Parametrised BIST pattern generator: LFSR, up-counter, walking-one and
// checkerboard sequences issued over a valid/ready stream, sequenced by a start/busy/done FSM.
module bist_pattern_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic [CNT_W-1:0]    num_patterns,
  bist_pattern_gen_if.master  pat,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [1:0] MODE_LFSR = 2'b00;
  localparam logic [1:0] MODE_CNT  = 2'b01;
  localparam logic [1:0] MODE_WALK = 2'b10;

  // LFSR and walking-one lock up on an all-zero state, so zero becomes 1 there.
  function automatic logic [WIDTH-1:0] sanitise(input logic [WIDTH-1:0] val,
                                                input logic [1:0]       m);
    if ((m == MODE_LFSR || m == MODE_WALK) && val == '0)
      return WIDTH'(1);
    return val;
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s,
                                               input logic [1:0]       m);
    case (m)
      MODE_LFSR: return {s[WIDTH-2:0], ^(s & TAPS)};
      MODE_CNT:  return s + WIDTH'(1);
      MODE_WALK: return {s[WIDTH-2:0], s[WIDTH-1]};
      default:   return ~s;
    endcase
  endfunction

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] idx_q;
  logic             last;
  logic             accept;

  assign last   = (idx_q == num_q - CNT_W'(1));
  assign accept = (fsm_q == RUN) && pat.pat_ready;

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (start) fsm_d = (num_patterns == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept && last) fsm_d = DONE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= sanitise(SEED, MODE_LFSR);
      mode_q  <= MODE_LFSR;
      num_q   <= '0;
      idx_q   <= '0;
    end else if (fsm_q != RUN) begin
      if (seed_load) state_q <= sanitise(seed_in, mode);
      if (start) begin
        mode_q <= mode;
        num_q  <= num_patterns;
        idx_q  <= '0;
      end
    end else if (accept) begin
      // State also advances on the final handshake so a fresh start continues the sequence.
      state_q <= advance(state_q, mode_q);
      if (!last) idx_q <= idx_q + CNT_W'(1);
    end
  end

  assign pat.pat_valid = (fsm_q == RUN);
  assign pat.pattern   = state_q;
  assign pat.pat_index = idx_q;
  assign busy          = (fsm_q == RUN);
  assign done          = (fsm_q == DONE);

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed-vector bench for bist_pattern_gen at WIDTH=4, TAPS=4'b1100.
module tb_bist_pattern_gen;
  localparam int W  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic          seed_load;
  logic [W-1:0]  seed_in;
  logic [CW-1:0] num_patterns;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  bist_pattern_gen_if #(.WIDTH(W), .CNT_W(CW)) pif ();

  bist_pattern_gen #(
    .WIDTH(W),
    .TAPS (4'b1100),
    .SEED (4'b0001),
    .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .num_patterns(num_patterns),
    .pat         (pif.master),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks each queued pattern as it is accepted, then the DONE state.
  task automatic drain(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_pat%0d", tag, i), 32'(pif.pattern), 32'(exp_q[i]));
      chk($sformatf("%s_idx%0d", tag, i), 32'(pif.pat_index), i);
      chk($sformatf("%s_vld%0d", tag, i), 32'(pif.pat_valid), 1);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_vld_end"}, 32'(pif.pat_valid), 0);
  endtask

  task automatic load_seed(input logic [1:0] m, input logic [W-1:0] s);
    mode = m; seed_in = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic go(input logic [1:0] m, input logic [CW-1:0] n);
    mode = m; num_patterns = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; seed_load = 1'b0;
    seed_in = '0; num_patterns = '0; pif.pat_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_vld",  32'(pif.pat_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pat",  32'(pif.pattern), 32'h1);
    chk("rst_idx",  32'(pif.pat_index), 0);

    // LFSR full period: 16th pattern wraps back to the seed
    load_seed(2'b00, 4'b0001);
    go(2'b00, 16);
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    drain("lfsr");

    // up-counter wrap, then a continuing 1-pattern run
    load_seed(2'b01, 4'b1110);
    go(2'b01, 4);
    exp_q = '{4'hE, 4'hF, 4'h0, 4'h1};
    drain("cnt");
    go(2'b01, 1);
    exp_q = '{4'h2};
    drain("cnt2");

    // walking-one, zero seed loaded together with start
    mode = 2'b10; seed_in = 4'b0000; seed_load = 1'b1;
    num_patterns = 5; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    drain("walk");

    // checkerboard with back-pressure; seed_load during RUN is ignored
    load_seed(2'b11, 4'b0101);
    pif.pat_ready = 1'b0;
    go(2'b11, 3);
    seed_in = 4'b1111; seed_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_pat%0d", i), 32'(pif.pattern), 32'h5);
      chk($sformatf("hold_idx%0d", i), 32'(pif.pat_index), 0);
      chk($sformatf("hold_vld%0d", i), 32'(pif.pat_valid), 1);
      tick();
    end
    seed_load = 1'b0;
    pif.pat_ready = 1'b1;
    exp_q = '{4'h5, 4'hA, 4'h5};
    drain("chk");

    // reset mid-run aborts without done, then a zero-length run
    load_seed(2'b00, 4'b0001);
    go(2'b00, 8);
    tick(); tick();
    chk("mid_pat", 32'(pif.pattern), 32'h4);
    chk("mid_idx", 32'(pif.pat_index), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_vld",  32'(pif.pat_valid), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pat",  32'(pif.pattern), 32'h1);
    chk("abort_idx",  32'(pif.pat_index), 0);
    go(2'b00, 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_vld",  32'(pif.pat_valid), 0);
    tick();
    chk("zero_done_hold", 32'(done), 1);
    chk("zero_vld_hold",  32'(pif.pat_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
